// File: rtl/pbkdf2_hmac_multi.sv
// pbkdf2_hmac_multi
// PBKDF2-HMAC-SHA256 (c=1) sequencer. It walks an external SHA-256
// compression core through the salt chain once (starting from the
// key^ipad midstate), caches the resulting midstate, and then for each
// output word T_i runs one inner compression (counter block) and one outer
// compression (key^opad midstate + inner digest).
//
// Ports
//   clk, reset_n      clock, asynchronous active-low reset
//   init              start pulse, accepted only while idle
//   in                salt, SALT_BLKS x 512 bits, block 0 in the MSBs
//   ixor_hash         SHA-256 state after the key^ipad block
//   oxor_hash         SHA-256 state after the key^opad block
//   out               derived key, DK_WORDS x 256 bits, T_1 in the MSBs
//   valid             one-cycle pulse when out is complete
//   busy              high from the cycle after init is accepted through valid
//   cmp_start         one-cycle compression request
//   cmp_state_in      chaining state for the request (held until cmp_done)
//   cmp_block         message block for the request (held until cmp_done)
//   cmp_done          compression result strobe
//   cmp_digest        compression result, valid while cmp_done is high
module pbkdf2_hmac_multi #(
  parameter int SALT_BLKS = 2,
  parameter int DK_WORDS  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     init,
  input  logic [SALT_BLKS*512-1:0] in,
  input  logic [255:0]             ixor_hash,
  input  logic [255:0]             oxor_hash,
  output logic [DK_WORDS*256-1:0]  out,
  output logic                     valid,
  output logic                     busy,
  output logic                     cmp_start,
  output logic [255:0]             cmp_state_in,
  output logic [511:0]             cmp_block,
  input  logic                     cmp_done,
  input  logic [255:0]             cmp_digest
);

  // Inner message length in bits: ipad block + salt + 4-byte counter.
  localparam logic [63:0] LEN_I  = 64'(512 + SALT_BLKS*512 + 32);
  localparam logic [15:0] J_LAST = 16'(SALT_BLKS - 1);
  localparam logic [7:0]  I_LAST = 8'(DK_WORDS);

  typedef enum logic [2:0] {
    IDLE, S_REQ, S_WAIT, I_REQ, I_WAIT, O_REQ, O_WAIT, DONE
  } state_t;

  state_t                   state;
  logic [15:0]              j;
  logic [7:0]               i;
  logic [SALT_BLKS*512-1:0] salt;
  logic [255:0]             oxor;
  logic [255:0]             mid;

  function automatic logic [511:0] salt_blk(input logic [SALT_BLKS*512-1:0] s,
                                            input logic [15:0] idx);
    return s[(SALT_BLKS - int'(idx))*512 - 1 -: 512];
  endfunction

  // Counter block: INT(i) followed by SHA-256 padding for the inner message.
  function automatic logic [511:0] inner_blk(input logic [7:0] idx);
    return {24'h0, idx, 32'h8000_0000, 384'h0, LEN_I};
  endfunction

  // Outer block: 32-byte inner digest after the 64-byte opad block = 768 bits.
  function automatic logic [511:0] outer_blk(input logic [255:0] d);
    return {d, 32'h8000_0000, 160'h0, 64'h300};
  endfunction

  // Job operands and the cached salt midstate are pure data; the FSM
  // never reads them before it has written them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && init) begin
      salt <= in;
      oxor <= oxor_hash;
    end
    if (state == S_WAIT && cmp_done) begin
      mid <= cmp_digest;
    end
  end

  // Each request is issued on the transition into a *_REQ state, so
  // cmp_start is high for exactly that one cycle and the operands stay put
  // until the matching *_WAIT sees cmp_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      j            <= '0;
      i            <= '0;
      out          <= '0;
      valid        <= 1'b0;
      busy         <= 1'b0;
      cmp_start    <= 1'b0;
      cmp_state_in <= '0;
      cmp_block    <= '0;
    end else begin
      cmp_start <= 1'b0;
      valid     <= 1'b0;
      case (state)
        IDLE: begin
          if (init) begin
            j            <= '0;
            i            <= 8'd1;
            busy         <= 1'b1;
            cmp_start    <= 1'b1;
            cmp_state_in <= ixor_hash;
            cmp_block    <= salt_blk(in, 16'd0);
            state        <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (cmp_done) begin
            // cmp_digest is the new chaining value (equal to mid next cycle).
            cmp_start    <= 1'b1;
            cmp_state_in <= cmp_digest;
            if (j < J_LAST) begin
              j         <= j + 16'd1;
              cmp_block <= salt_blk(salt, j + 16'd1);
              state     <= S_REQ;
            end else begin
              cmp_block <= inner_blk(i);
              state     <= I_REQ;
            end
          end
        end
        I_REQ: state <= I_WAIT;
        I_WAIT: begin
          if (cmp_done) begin
            cmp_start    <= 1'b1;
            cmp_state_in <= oxor;
            cmp_block    <= outer_blk(cmp_digest);
            state        <= O_REQ;
          end
        end
        O_REQ: state <= O_WAIT;
        O_WAIT: begin
          if (cmp_done) begin
            out[(DK_WORDS - int'(i) + 1)*256 - 1 -: 256] <= cmp_digest;
            if (i < I_LAST) begin
              i            <= i + 8'd1;
              cmp_start    <= 1'b1;
              cmp_state_in <= mid;
              cmp_block    <= inner_blk(i + 8'd1);
              state        <= I_REQ;
            end else begin
              valid <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbkdf2_hmac_multi.sv
// Testbench for pbkdf2_hmac_multi: three configurations (SALT_BLKS/DK_WORDS
// = 2/1, 2/3, 1/2), each driven by a behavioural SHA-256 compression core
// with a programmable latency, checked against a PBKDF2-HMAC-SHA256 model.
module tb_pbkdf2_hmac_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // SHA-256 compression with feed-forward.
  function automatic logic [255:0] sha_cmp(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int k = 0; k < 16; k++) w[k] = m[511 - 32*k -: 32];
    for (int k = 16; k < 64; k++)
      w[k] = w[k-16] + (ror(w[k-15], 7) ^ ror(w[k-15], 18) ^ (w[k-15] >> 3))
           + w[k-7] + (ror(w[k-2], 17) ^ ror(w[k-2], 19) ^ (w[k-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int k = 0; k < 64; k++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[k] + w[k];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // PBKDF2 reference: salt is left-aligned in 1024 bits (block k at the top).
  function automatic logic [255:0] ref_mid(input logic [1023:0] s, input int sb, input logic [255:0] ih);
    logic [255:0] h;
    h = ih;
    for (int k = 0; k < sb; k++) h = sha_cmp(h, s[1023 - 512*k -: 512]);
    return h;
  endfunction

  function automatic logic [511:0] ref_inner_blk(input int sb, input int idx);
    // bytes hashed: 64 (ipad) + salt + 4 (counter)
    return {32'(idx), 32'h8000_0000, 384'h0, 64'((64 + 64*sb + 4) * 8)};
  endfunction

  function automatic logic [255:0] ref_inner(input logic [255:0] mid, input int sb, input int idx);
    return sha_cmp(mid, ref_inner_blk(sb, idx));
  endfunction

  // Result left-aligned in 768 bits, T_1 at the top.
  function automatic logic [767:0] ref_dk(input logic [255:0] mid, input logic [255:0] oh,
                                          input int sb, input int dk);
    logic [767:0] r;
    r = '0;
    for (int n = 1; n <= dk; n++)
      r[767 - 256*(n-1) -: 256] = sha_cmp(oh, {ref_inner(mid, sb, n), 32'h8000_0000, 160'h0,
                                               64'((64 + 32) * 8)});
    return r;
  endfunction

  function automatic logic [1023:0] rnd1k();
    logic [1023:0] r;
    for (int k = 0; k < 32; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: SALT_BLKS=2, DK_WORDS=1 ----------------
  logic          init_a = 1'b0;
  logic [1023:0] in_a   = '0;
  logic [255:0]  ih_a   = '0, oh_a = '0;
  logic [255:0]  out_a, st_a, dig_a;
  logic [511:0]  blk_a;
  logic          valid_a, busy_a, start_a, done_a;
  logic          done_r_a = 1'b0, spur_a = 1'b0;
  logic [255:0]  dig_r_a = '0;
  int            cnt_a = 0, lat_a = 3, nreq_a = 0, vcnt_a = 0, spur_idx_a = -1;
  logic [255:0]  lst_a [64];
  logic [511:0]  lbk_a [64];

  // Optional spurious strobe while the selected request is being issued.
  assign done_a = done_r_a | (spur_a & start_a & (nreq_a == spur_idx_a));
  assign dig_a  = done_r_a ? dig_r_a : {8{32'hdeadbeef}};

  pbkdf2_hmac_multi #(.SALT_BLKS(2), .DK_WORDS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .init(init_a), .in(in_a),
    .ixor_hash(ih_a), .oxor_hash(oh_a), .out(out_a), .valid(valid_a), .busy(busy_a),
    .cmp_start(start_a), .cmp_state_in(st_a), .cmp_block(blk_a),
    .cmp_done(done_a), .cmp_digest(dig_a));

  always @(posedge clk) begin
    done_r_a <= 1'b0;
    if (cnt_a == 1) begin done_r_a <= 1'b1; dig_r_a <= sha_cmp(st_a, blk_a); end
    if (cnt_a > 0) cnt_a <= cnt_a - 1;
    if (start_a) begin
      lst_a[6'(nreq_a)] <= st_a;
      lbk_a[6'(nreq_a)] <= blk_a;
      nreq_a <= nreq_a + 1;
      if (lat_a == 1) begin done_r_a <= 1'b1; dig_r_a <= sha_cmp(st_a, blk_a); end
      else cnt_a <= lat_a - 1;
    end
    if (valid_a) vcnt_a <= vcnt_a + 1;
  end

  // ---------------- instance B: SALT_BLKS=2, DK_WORDS=3 ----------------
  logic          init_b = 1'b0;
  logic [1023:0] in_b   = '0;
  logic [255:0]  ih_b   = '0, oh_b = '0;
  logic [767:0]  out_b;
  logic [255:0]  st_b;
  logic [511:0]  blk_b;
  logic          valid_b, busy_b, start_b;
  logic          done_r_b = 1'b0;
  logic [255:0]  dig_r_b = '0;
  int            cnt_b = 0, lat_b = 2, nreq_b = 0;
  logic [255:0]  lst_b [64];
  logic [511:0]  lbk_b [64];

  pbkdf2_hmac_multi #(.SALT_BLKS(2), .DK_WORDS(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .init(init_b), .in(in_b),
    .ixor_hash(ih_b), .oxor_hash(oh_b), .out(out_b), .valid(valid_b), .busy(busy_b),
    .cmp_start(start_b), .cmp_state_in(st_b), .cmp_block(blk_b),
    .cmp_done(done_r_b), .cmp_digest(dig_r_b));

  always @(posedge clk) begin
    done_r_b <= 1'b0;
    if (cnt_b == 1) begin done_r_b <= 1'b1; dig_r_b <= sha_cmp(st_b, blk_b); end
    if (cnt_b > 0) cnt_b <= cnt_b - 1;
    if (start_b) begin
      lst_b[6'(nreq_b)] <= st_b;
      lbk_b[6'(nreq_b)] <= blk_b;
      nreq_b <= nreq_b + 1;
      if (lat_b == 1) begin done_r_b <= 1'b1; dig_r_b <= sha_cmp(st_b, blk_b); end
      else cnt_b <= lat_b - 1;
    end
  end

  // ---------------- instance C: SALT_BLKS=1, DK_WORDS=2 ----------------
  logic          init_c = 1'b0;
  logic [511:0]  in_c   = '0;
  logic [255:0]  ih_c   = '0, oh_c = '0;
  logic [511:0]  out_c;
  logic [255:0]  st_c;
  logic [511:0]  blk_c;
  logic          valid_c, busy_c, start_c;
  logic          done_r_c = 1'b0;
  logic [255:0]  dig_r_c = '0;
  int            cnt_c = 0, lat_c = 1, nreq_c = 0;
  logic [255:0]  lst_c [64];
  logic [511:0]  lbk_c [64];

  pbkdf2_hmac_multi #(.SALT_BLKS(1), .DK_WORDS(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .init(init_c), .in(in_c),
    .ixor_hash(ih_c), .oxor_hash(oh_c), .out(out_c), .valid(valid_c), .busy(busy_c),
    .cmp_start(start_c), .cmp_state_in(st_c), .cmp_block(blk_c),
    .cmp_done(done_r_c), .cmp_digest(dig_r_c));

  always @(posedge clk) begin
    done_r_c <= 1'b0;
    if (cnt_c == 1) begin done_r_c <= 1'b1; dig_r_c <= sha_cmp(st_c, blk_c); end
    if (cnt_c > 0) cnt_c <= cnt_c - 1;
    if (start_c) begin
      lst_c[6'(nreq_c)] <= st_c;
      lbk_c[6'(nreq_c)] <= blk_c;
      nreq_c <= nreq_c + 1;
      if (lat_c == 1) begin done_r_c <= 1'b1; dig_r_c <= sha_cmp(st_c, blk_c); end
      else cnt_c <= lat_c - 1;
    end
  end

  // Pulse init for one cycle from a falling edge; t = edge that samples it.
  task automatic go_a(input logic [1023:0] s, input logic [255:0] ih, input logic [255:0] oh, output int t);
    in_a = s; ih_a = ih; oh_a = oh; init_a = 1'b1;
    @(negedge clk);
    t = cyc; init_a = 1'b0;
  endtask

  // Poll at falling edges; vt = edge that samples valid, -1 on timeout.
  task automatic wait_valid_a(output int vt);
    vt = -1;
    for (int k = 0; k < 300; k++) begin
      if (valid_a === 1'b1) begin vt = cyc + 1; return; end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid_b(output int vt);
    vt = -1;
    for (int k = 0; k < 300; k++) begin
      if (valid_b === 1'b1) begin vt = cyc + 1; return; end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid_c(output int vt);
    vt = -1;
    for (int k = 0; k < 300; k++) begin
      if (valid_c === 1'b1) begin vt = cyc + 1; return; end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [1023:0] s, s1, s2;
    logic [255:0]  ih, oh, ih1, oh1, ih2, oh2, mid;
    logic [767:0]  dk, dk1, dk2;
    int            t, t2, vt, n0, n1, v0;

    repeat (3) @(negedge clk);
    chk("rst_out", 512'(out_a), 512'(0));
    chk("rst_ctrl", 512'({valid_a, busy_a, start_a}), 512'(0));
    chk("rst_state_in", 512'(st_a), 512'(0));
    chk("rst_block", blk_a, 512'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Test 1: A, L=3
    s1 = rnd1k(); ih1 = rnd256(); oh1 = rnd256();
    mid = ref_mid(s1, 2, ih1); dk1 = ref_dk(mid, oh1, 2, 1);
    n0 = nreq_a; v0 = vcnt_a;
    go_a(s1, ih1, oh1, t);
    wait_valid_a(vt);
    chk("t1_latency", 512'(vt), 512'(t + 17));
    chk("t1_busy_at_valid", 512'(busy_a), 512'(1));
    chk("t1_nreq", 512'(nreq_a - n0), 512'(4));
    chk("t1_req0_state", 512'(lst_a[6'(n0)]), 512'(ih1));
    chk("t1_req0_blk", lbk_a[6'(n0)], s1[1023:512]);
    chk("t1_req1_blk", lbk_a[6'(n0 + 1)], s1[511:0]);
    chk("t1_req2_state", 512'(lst_a[6'(n0 + 2)]), 512'(mid));
    chk("t1_req2_blk", lbk_a[6'(n0 + 2)], {32'h1, 32'h8000_0000, 384'h0, 64'h620});
    chk("t1_req3_state", 512'(lst_a[6'(n0 + 3)]), 512'(oh1));
    chk("t1_out", 512'(out_a), 512'(dk1[767:512]));
    @(negedge clk);
    chk("t1_idle_after", 512'({valid_a, busy_a}), 512'(0));
    chk("t1_vcount", 512'(vcnt_a - v0), 512'(1));

    // Test 2: B, DK_WORDS=3, L=2
    s = rnd1k(); ih = rnd256(); oh = rnd256();
    mid = ref_mid(s, 2, ih); dk = ref_dk(mid, oh, 2, 3);
    n0 = nreq_b;
    in_b = s; ih_b = ih; oh_b = oh; init_b = 1'b1;
    @(negedge clk);
    t = cyc; init_b = 1'b0;
    wait_valid_b(vt);
    chk("t2_latency", 512'(vt), 512'(t + 1 + 8*3));
    chk("t2_busy_at_valid", 512'(busy_b), 512'(1));
    chk("t2_nreq", 512'(nreq_b - n0), 512'(8));
    chk("t2_salt0_blk", lbk_b[6'(n0)], s[1023:512]);
    chk("t2_salt1_blk", lbk_b[6'(n0 + 1)], s[511:0]);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t2_inner%0d_state", k + 1), 512'(lst_b[6'(n0 + 2 + 2*k)]), 512'(mid));
      chk($sformatf("t2_inner%0d_blk", k + 1), lbk_b[6'(n0 + 2 + 2*k)], ref_inner_blk(2, k + 1));
      chk($sformatf("t2_outer%0d_state", k + 1), 512'(lst_b[6'(n0 + 3 + 2*k)]), 512'(oh));
      chk($sformatf("t2_out_T%0d", k + 1), 512'(out_b[767 - 256*k -: 256]), 512'(dk[767 - 256*k -: 256]));
    end

    // Test 3: C, SALT_BLKS=1, DK_WORDS=2, L=1
    s = rnd1k(); ih = rnd256(); oh = rnd256();
    mid = ref_mid(s, 1, ih); dk = ref_dk(mid, oh, 1, 2);
    n0 = nreq_c;
    in_c = s[1023:512]; ih_c = ih; oh_c = oh; init_c = 1'b1;
    @(negedge clk);
    t = cyc; init_c = 1'b0;
    wait_valid_c(vt);
    chk("t3_latency", 512'(vt), 512'(t + 1 + 5*2));
    chk("t3_busy_at_valid", 512'(busy_c), 512'(1));
    chk("t3_req0_state", 512'(lst_c[6'(n0)]), 512'(ih));
    chk("t3_inner1_blk", lbk_c[6'(n0 + 1)], {32'h1, 32'h8000_0000, 384'h0, 64'h420});
    chk("t3_outer_state", 512'(lst_c[6'(n0 + 2)]), 512'(oh));
    chk("t3_outer_trailer", 512'(lbk_c[6'(n0 + 2)][63:0]), 512'(64'h300));
    chk("t3_outer_blk", lbk_c[6'(n0 + 2)], {ref_inner(mid, 1, 1), 32'h8000_0000, 160'h0, 64'h300});
    chk("t3_inner2_blk", lbk_c[6'(n0 + 3)], {32'h2, 32'h8000_0000, 384'h0, 64'h420});
    chk("t3_out", out_c, dk[767:256]);

    // Test 4: A, init held during the job with changing inputs, spurious done in I_REQ
    n0 = nreq_a; v0 = vcnt_a;
    spur_idx_a = nreq_a + 2; spur_a = 1'b1;
    go_a(s1, ih1, oh1, t);
    vt = -1;
    for (int k = 0; k < 300; k++) begin
      if (valid_a === 1'b1) begin vt = cyc + 1; break; end
      init_a = 1'b1; in_a = rnd1k(); ih_a = rnd256(); oh_a = rnd256();
      @(negedge clk);
    end
    init_a = 1'b0; spur_a = 1'b0;
    chk("t4_latency", 512'(vt), 512'(t + 17));
    chk("t4_out_same", 512'(out_a), 512'(dk1[767:512]));
    chk("t4_nreq", 512'(nreq_a - n0), 512'(4));
    repeat (20) @(negedge clk);
    chk("t4_single_valid", 512'(vcnt_a - v0), 512'(1));

    // Test 5: A, reset during I_WAIT, then a fresh job
    s = rnd1k(); ih = rnd256(); oh = rnd256();
    n0 = nreq_a;
    go_a(s, ih, oh, t);
    for (int k = 0; k < 100 && (nreq_a - n0) < 3; k++) @(negedge clk);
    chk("t5_reached_iwait", 512'(nreq_a - n0), 512'(3));
    reset_n = 1'b0;
    #1;
    chk("t5_rst_out", 512'(out_a), 512'(0));
    chk("t5_rst_ctrl", 512'({valid_a, busy_a, start_a}), 512'(0));
    chk("t5_rst_cmp", {st_a, blk_a[255:0]}, 512'(0));
    @(negedge clk);
    reset_n = 1'b1;
    v0 = vcnt_a;
    repeat (40) @(negedge clk);
    chk("t5_no_valid", 512'(vcnt_a - v0), 512'(0));
    dk = ref_dk(ref_mid(s, 2, ih), oh, 2, 1);
    go_a(s, ih, oh, t);
    wait_valid_a(vt);
    chk("t5_fresh_latency", 512'(vt), 512'(t + 17));
    chk("t5_fresh_out", 512'(out_a), 512'(dk[767:512]));
    @(negedge clk);

    // Test 6: A, back-to-back jobs; init in DONE is ignored, first IDLE cycle accepted
    s1 = rnd1k(); ih1 = rnd256(); oh1 = rnd256();
    s2 = rnd1k(); ih2 = rnd256(); oh2 = rnd256();
    dk1 = ref_dk(ref_mid(s1, 2, ih1), oh1, 2, 1);
    dk2 = ref_dk(ref_mid(s2, 2, ih2), oh2, 2, 1);
    v0 = vcnt_a;
    go_a(s1, ih1, oh1, t);
    wait_valid_a(vt);
    chk("t6_job1_latency", 512'(vt), 512'(t + 17));
    in_a = s2; ih_a = ih2; oh_a = oh2; init_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    t2 = cyc; init_a = 1'b0;
    n1 = nreq_a;
    chk("t6_out_holds_job1", 512'(out_a), 512'(dk1[767:512]));
    for (int k = 0; k < 100 && (nreq_a - n1) < 4; k++) @(negedge clk);
    chk("t6_out_before_outer", 512'(out_a), 512'(dk1[767:512]));
    wait_valid_a(vt);
    chk("t6_job2_latency", 512'(vt), 512'(t2 + 17));
    chk("t6_job2_out", 512'(out_a), 512'(dk2[767:512]));
    repeat (5) @(negedge clk);
    chk("t6_two_valids", 512'(vcnt_a - v0), 512'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
